// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 slave with a 2^ADDR_W x DATA_W register array and a local write port
module spi_slave_regfile #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              lcl_we,
    input  logic [ADDR_W-1:0] lcl_addr,
    input  logic [DATA_W-1:0] lcl_wdata,
    output logic              lcl_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic              frame_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t              state;
    logic [1:0]          sclk_s, cs_s, mosi_s;
    logic                sclk_h, cs_h;
    logic [5:0]          bit_cnt;
    logic [DATA_W-2:0]   shift;
    logic [DATA_W-1:0]   tx_reg;
    logic [ADDR_W-1:0]   addr;
    logic                is_read;
    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    wire sclk_rise = sclk_s[1] & ~sclk_h;
    wire sclk_fall = ~sclk_s[1] & sclk_h;
    wire cs_fall   = ~cs_s[1] & cs_h;
    wire cs_high   = cs_s[1];
    wire mosi_bit  = mosi_s[1];

    // The pending SPI commit owns the array write port for one cycle
    assign lcl_ready = ~wr_valid;

    // Two-flop synchronisers plus edge-history flops for the SPI pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_h <= 1'b0;
            cs_h   <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], spi_sclk};
            cs_s   <= {cs_s[0], spi_cs_n};
            mosi_s <= {mosi_s[0], spi_mosi};
            sclk_h <= sclk_s[1];
            cs_h   <= cs_s[1];
        end
    end

    // Frame state machine: command decode, MISO shifting, commit and abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_reg    <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            spi_miso  <= 1'b0;
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        state  <= CMD;
                        busy   <= 1'b1;
                        shift  <= '0;
                        tx_reg <= '0;
                    end
                end
                CMD: begin
                    if (cs_high) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        spi_miso  <= 1'b0;
                    end else if (sclk_rise) begin
                        shift   <= {shift[DATA_W-3:0], mosi_bit};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd15) begin
                            state    <= DATA;
                            addr     <= shift[ADDR_W+1:2];
                            is_read  <= shift[0];
                            rd_valid <= shift[0];
                        end
                    end
                end
                DATA: begin
                    if (cs_high) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        spi_miso  <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            spi_miso <= tx_reg[DATA_W-1];
                            tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
                        end
                        if (rd_valid)
                            tx_reg <= mem[addr];
                        if (sclk_rise) begin
                            shift   <= {shift[DATA_W-3:0], mosi_bit};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                state    <= DONE;
                                spi_miso <= 1'b0;
                                if (!is_read) begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= addr;
                                    wr_data  <= {shift, mosi_bit};
                                end
                            end
                        end
                    end
                end
                default: begin
                    spi_miso <= 1'b0;
                    if (cs_high) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array write port: SPI commit first, local write otherwise; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_valid)
            mem[wr_addr] <= wr_data;
        else if (lcl_we)
            mem[lcl_addr] <= lcl_wdata;
    end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: directed and randomized frames checked against an array model
module tb_spi_slave_regfile;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        lcl_we = 1'b0;
    logic [7:0]  lcl_addr = '0;
    logic [15:0] lcl_wdata = '0;
    logic        lcl_ready, wr_valid, rd_valid, frame_err, busy;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    int tests = 0;
    int fails = 0;
    int n_wr = 0, n_rd = 0, n_fe = 0;
    logic [7:0]  cap_addr = '0;
    logic [15:0] cap_data = '0;

    logic [15:0] model [256];
    logic        known [256];
    logic [7:0]  wlist [$];

    spi_slave_regfile dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .lcl_we(lcl_we), .lcl_addr(lcl_addr),
        .lcl_wdata(lcl_wdata), .lcl_ready(lcl_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (rd_valid) n_rd++;
        if (frame_err) n_fe++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mkcmd(input logic [7:0] a, input logic rd);
        logic [4:0] hi = 5'($urandom);
        logic       b2 = 1'($urandom);
        logic       b0 = 1'($urandom);
        return {hi, a, b2, rd, b0};
    endfunction

    task automatic frame(input logic [31:0] w, input int n, output logic [31:0] rx, output int xbad);
        rx = '0;
        xbad = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_mosi = (i < 32) ? w[31-i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            if (i < 32) rx = {rx[30:0], spi_miso};
            else if (spi_miso !== 1'b0) xbad++;
            if (i < n - 1) begin
                repeat (HALF) @(negedge clk);
                spi_sclk = 1'b0;
            end
        end
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [15:0] d, input int n);
        logic [31:0] rx;
        int xbad, w0;
        w0 = n_wr;
        frame({mkcmd(a, 1'b0), d}, n, rx, xbad);
        end_frame();
        chk("wr_pulse", 32'(n_wr - w0), 32'd1);
        chk("wr_addr", {24'd0, cap_addr}, {24'd0, a});
        chk("wr_data", {16'd0, cap_data}, {16'd0, d});
        chk("wr_miso_zero", rx | 32'(xbad), 32'd0);
        model[a] = d;
        known[a] = 1'b1;
        wlist.push_back(a);
    endtask

    task automatic spi_read(input logic [7:0] a, input int n);
        logic [31:0] rx;
        int xbad, r0, w0;
        r0 = n_rd;
        w0 = n_wr;
        frame({mkcmd(a, 1'b1), 16'($urandom)}, n, rx, xbad);
        end_frame();
        chk("rd_pulse", 32'(n_rd - r0), 32'd1);
        chk("rd_no_wr", 32'(n_wr - w0), 32'd0);
        chk("rd_data", {16'd0, rx[15:0]}, {16'd0, model[a]});
        chk("rd_extra_miso", 32'(xbad), 32'd0);
    endtask

    task automatic lcl_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        lcl_we = 1'b1;
        lcl_addr = a;
        lcl_wdata = d;
        chk("lcl_ready", {31'd0, lcl_ready}, 32'd1);
        @(negedge clk);
        lcl_we = 1'b0;
        model[a] = d;
        known[a] = 1'b1;
        wlist.push_back(a);
    endtask

    initial begin
        logic [31:0] rx;
        int xbad, f0, w0, found;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {26'd0, spi_miso, wr_valid, rd_valid, frame_err, busy, lcl_ready}, 32'd1);
        chk("rst_wr", {8'd0, wr_addr, wr_data}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        lcl_write(8'h1A, 16'hC0DE);
        spi_read(8'h1A, 32);
        spi_write(8'h1A, 16'hBEEF, 32);
        spi_read(8'h1A, 32);

        lcl_write(8'h05, 16'h1234);
        f0 = n_fe;
        w0 = n_wr;
        frame({mkcmd(8'h05, 1'b0), 16'hFACE}, 20, rx, xbad);
        end_frame();
        chk("abort_fe", 32'(n_fe - f0), 32'd1);
        chk("abort_no_wr", 32'(n_wr - w0), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        spi_read(8'h05, 32);

        frame({mkcmd(8'h05, 1'b0), 16'hAAAA}, 32, rx, xbad);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (wr_valid) begin
                found = 1;
                lcl_we = 1'b1;
                lcl_addr = 8'h05;
                lcl_wdata = 16'h5555;
                chk("coll_ready_low", {31'd0, lcl_ready}, 32'd0);
                @(negedge clk);
                chk("coll_ready_high", {31'd0, lcl_ready}, 32'd1);
                @(posedge clk);
                #1 lcl_we = 1'b0;
            end
        end
        chk("coll_commit_seen", 32'(found), 32'd1);
        end_frame();
        model[8'h05] = 16'h5555;
        spi_read(8'h05, 32);

        spi_write(8'h40, 16'h0F0F, 40);
        spi_read(8'h40, 40);
        spi_read(8'h1A, 40);

        for (int it = 0; it < 12; it++) begin
            int op = int'($urandom_range(0, 2));
            logic [7:0] a = 8'($urandom);
            logic [15:0] d = 16'($urandom);
            if (op == 0) lcl_write(a, d);
            else if (op == 1) spi_write(a, d, 32);
            else spi_read(wlist[$urandom_range(0, wlist.size() - 1)], 32);
        end

        frame({mkcmd(8'h77, 1'b0), 16'h9999}, 24, rx, xbad);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {26'd0, spi_miso, wr_valid, rd_valid, frame_err, busy, lcl_ready}, 32'd1);
        chk("async_rst_wr", {8'd0, wr_addr, wr_data}, 32'd0);
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_read(8'h40, 32);
        spi_write(8'h77, 16'h8421, 32);
        spi_read(8'h77, 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
